// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the RV32 memory stage.
// Services lb/lh/lw/lbu/lhu loads and sb/sh/sw stores on a DEPTH x 32-bit
// array. Load results and the error flag are registered, so writeback sees
// them one cycle after issue.
//
// Optional feature macro: DMEM_CLEAR_EN compiles in a post-reset clear engine
// that zeroes every word and holds off requests (busy=1) while it runs.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mem_re     load request
//   mem_we     store request
//   func3      RV32 access size / signedness
//   addr       byte address; word index is addr[AW+1:2], upper bits ignored
//   wdata      right-aligned store data
//   rdata      registered, extended load result
//   misaligned one-cycle pulse for misaligned / illegal / conflicting access
//   busy       high while the clear engine runs
module dmem_responder #(
   parameter int DEPTH = 1024,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_re,
   input  logic        mem_we,
   input  logic [2:0]  func3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        busy
);

   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] idx;
   logic [1:0]    off;
   logic [31:0]   word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_val;
   logic          size_ok;
   logic          load_ok;
   logic          store_ok;

   logic          clearing;
   logic [AW-1:0] clr_idx;

   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic [3:0]    wr_lanes;
   logic [31:0]   wr_data;

   logic          unused_addr_bits;

   assign idx              = addr[AW+1:2];
   assign off              = addr[1:0];
   assign unused_addr_bits = ^addr[31:AW+2];

`ifdef DMEM_CLEAR_EN
   typedef enum logic {CLEAR, READY} state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] clr_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      if (state == CLEAR && clr_cnt == AW'(DEPTH - 1)) begin
         state_next = READY;
      end
   end

   always_comb begin
      busy     = (state == CLEAR);
      clearing = (state == CLEAR);
      clr_idx  = clr_cnt;
   end
`else
   always_comb begin
      busy     = 1'b0;
      clearing = 1'b0;
      clr_idx  = '0;
   end
`endif

   // Legality: size from func3[1:0], signed/unsigned from func3[2].
   always_comb begin
      case (func3[1:0])
         2'b00:   size_ok = 1'b1;
         2'b01:   size_ok = ~off[0];
         2'b10:   size_ok = (off == 2'b00);
         default: size_ok = 1'b0;
      endcase
      load_ok  = size_ok && (func3 != 3'b110);
      store_ok = size_ok && !func3[2];
   end

   always_comb begin
      word     = mem[idx];
      byte_sel = word[{off, 3'b000} +: 8];
      half_sel = off[1] ? word[31:16] : word[15:0];
      case (func3)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_val = {24'd0, byte_sel};
         3'b101:  load_val = {16'd0, half_sel};
         default: load_val = word;
      endcase
   end

   // Write port is shared: the clear engine owns it while busy. Writes are
   // gated by rst_n so a request held during reset cannot touch the array.
   always_comb begin
      wr_en    = 1'b0;
      wr_idx   = idx;
      wr_lanes = '0;
      wr_data  = wdata;
      if (clearing) begin
         wr_en    = rst_n;
         wr_idx   = clr_idx;
         wr_lanes = '1;
         wr_data  = '0;
      end else if (mem_we && store_ok) begin
         wr_en = rst_n;
         case (func3[1:0])
            2'b00: begin
               wr_lanes = 4'b0001 << off;
               wr_data  = {4{wdata[7:0]}};
            end
            2'b01: begin
               wr_lanes = off[1] ? 4'b1100 : 4'b0011;
               wr_data  = {2{wdata[15:0]}};
            end
            default: begin
               wr_lanes = '1;
               wr_data  = wdata;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (wr_lanes[i]) begin
               mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   // A simultaneous load+store keeps rdata; a rejected lone access zeroes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata      <= '0;
         misaligned <= 1'b0;
      end else begin
         misaligned <= 1'b0;
         if (!busy) begin
            if (mem_re && mem_we) begin
               misaligned <= 1'b1;
            end else if (mem_we) begin
               if (!store_ok) begin
                  misaligned <= 1'b1;
                  rdata      <= '0;
               end
            end else if (mem_re) begin
               if (load_ok) begin
                  rdata <= load_val;
               end else begin
                  misaligned <= 1'b1;
                  rdata      <= '0;
               end
            end
         end
      end
   end

endmodule
